// File: rtl/tube_scan_driver.sv
// Time-multiplexed 7-segment driver: scans DIGITS digits with dead-time, hex decode,
// leading-zero blanking and a double-buffered display word that only changes at frame wrap.
module tube_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD           = 2,
  parameter int HEX_MODE       = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_N,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   numbers,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW != 0}};

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_stg_num, r_disp_num;
  logic [DIGITS-1:0]     r_stg_en, r_disp_en, r_stg_dp, r_disp_dp;
  logic                  r_stg_lz, r_disp_lz, r_pending;

  logic                  w_tick, w_wrap, w_dark, w_zero_run;
  logic [3:0]            w_val;
  logic [DIGITS-1:0]     w_blank, w_onehot;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      4'hA: s = (HEX_MODE != 0) ? 7'b0001000 : 7'b0111111;
      4'hB: s = (HEX_MODE != 0) ? 7'b0000011 : 7'b0111111;
      4'hC: s = (HEX_MODE != 0) ? 7'b1000110 : 7'b0111111;
      4'hD: s = (HEX_MODE != 0) ? 7'b0100001 : 7'b0111111;
      4'hE: s = (HEX_MODE != 0) ? 7'b0000110 : 7'b0111111;
      default: s = (HEX_MODE != 0) ? 7'b0001110 : 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick   = enable && (r_cnt == CW'(CLK_DIV - 1));
  assign w_wrap   = w_tick && (r_idx == IW'(DIGITS - 1));
  assign w_val    = r_disp_num[{r_idx, 2'b00} +: 4];
  assign w_onehot = DIGITS'(1) << r_idx;

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_disp_num[4*i +: 4] == 4'd0);
      w_blank[i] = r_disp_lz & w_zero_run;
    end
  end

  assign w_dark = !enable || (int'(r_cnt) < DEAD) || !r_disp_en[r_idx] || w_blank[r_idx];

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt      <= '0;
      r_idx      <= '0;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + CW'(1);
      frame_done <= w_wrap;
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IW'(1);
    end
  end

  // A load in the wrap cycle is staged; the wrap itself commits the older staging contents.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      // NOTE: the buffers are plain flops, so clearing them on reset is cheap and required.
      r_stg_num  <= '0;
      r_stg_en   <= '0;
      r_stg_dp   <= '0;
      r_stg_lz   <= 1'b0;
      r_disp_num <= '0;
      r_disp_en  <= '0;
      r_disp_dp  <= '0;
      r_disp_lz  <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_disp_num <= r_stg_num;
        r_disp_en  <= r_stg_en;
        r_disp_dp  <= r_stg_dp;
        r_disp_lz  <= r_stg_lz;
      end
      if (load) begin
        r_stg_num <= numbers;
        r_stg_en  <= digit_en;
        r_stg_dp  <= dp;
        r_stg_lz  <= blank_lz;
        if (!enable) begin
          r_disp_num <= numbers;
          r_disp_en  <= digit_en;
          r_disp_dp  <= dp;
          r_disp_lz  <= blank_lz;
        end
      end
      if (load)        r_pending <= 1'b1;
      else if (w_wrap) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      seg_out <= 7'b1111111;
      dp_out  <= 1'b1;
      sel_out <= SEL_OFF;
    end else if (w_dark) begin
      seg_out <= 7'b1111111;
      dp_out  <= 1'b1;
      sel_out <= SEL_OFF;
    end else begin
      seg_out <= decode(w_val);
      dp_out  <= ~r_disp_dp[r_idx];
      sel_out <= SEL_OFF ^ w_onehot;
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Bench for tube_scan_driver (4 digits, 8-cycle slots, 2 dead cycles): directed scenarios
// and random traffic checked every cycle against a slot-position reference model.
module tb_tube_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int NPOS    = DIGITS * CLK_DIV;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic rst_N, enable, load, blank_lz;
  logic [15:0] numbers;
  logic [3:0]  digit_en, dp;
  logic [6:0]  seg_out, seg_h0;
  logic        dp_out, dp_h0, fd, fd_h0;
  logic [3:0]  sel_out, sel_h0;

  always #5 clk = ~clk;

  tube_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD), .HEX_MODE(1), .SEL_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_N(rst_N), .enable(enable), .numbers(numbers), .digit_en(digit_en),
    .dp(dp), .blank_lz(blank_lz), .load(load), .seg_out(seg_out), .dp_out(dp_out),
    .sel_out(sel_out), .frame_done(fd));

  tube_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD), .HEX_MODE(0), .SEL_ACTIVE_LOW(1)) dut_h0 (
    .clk(clk), .rst_N(rst_N), .enable(enable), .numbers(numbers), .digit_en(digit_en),
    .dp(dp), .blank_lz(blank_lz), .load(load), .seg_out(seg_h0), .dp_out(dp_h0),
    .sel_out(sel_h0), .frame_done(fd_h0));

  int total = 0;
  int bad   = 0;

  // Reference model: scan position within the frame plus staged/displayed digit arrays.
  int         m_pos;
  logic [3:0] m_dig [DIGITS];
  logic [3:0] s_dig [DIGITS];
  logic [3:0] m_en, m_dp, s_en, s_dp;
  logic       m_lz, s_lz, m_pend;
  logic [6:0] e_seg, e_seg0;
  logic       e_dp, e_fd;
  logic [3:0] e_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    for (int j = 0; j < DIGITS; j++) begin
      m_dig[j] = '0;
      s_dig[j] = '0;
    end
    m_en = '0; m_dp = '0; s_en = '0; s_dp = '0;
    m_lz = 1'b0; s_lz = 1'b0; m_pend = 1'b0;
    e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_fd = 1'b0;
  endtask

  task automatic model_step();
    int  idx, cnt;
    bit  zeros, dark, wrap;
    idx   = m_pos / CLK_DIV;
    cnt   = m_pos % CLK_DIV;
    zeros = 1'b1;
    for (int j = idx; j < DIGITS; j++) if (m_dig[j] != 4'd0) zeros = 1'b0;
    dark   = !enable || (cnt < DEAD) || !m_en[idx] || (m_lz && idx > 0 && zeros);
    e_seg  = dark ? 7'h7F : SEG_TBL[m_dig[idx]];
    e_seg0 = dark ? 7'h7F : ((m_dig[idx] > 4'd9) ? DASH : SEG_TBL[m_dig[idx]]);
    e_dp   = dark ? 1'b1 : !m_dp[idx];
    e_sel  = dark ? 4'hF : ~(4'b0001 << idx);
    wrap   = enable && (m_pos == NPOS - 1);
    e_fd   = wrap;
    if (wrap && m_pend) begin
      for (int j = 0; j < DIGITS; j++) m_dig[j] = s_dig[j];
      m_en = s_en; m_dp = s_dp; m_lz = s_lz;
    end
    if (load) begin
      for (int j = 0; j < DIGITS; j++) s_dig[j] = numbers[4*j +: 4];
      s_en = digit_en; s_dp = dp; s_lz = blank_lz;
      if (!enable) begin
        for (int j = 0; j < DIGITS; j++) m_dig[j] = numbers[4*j +: 4];
        m_en = digit_en; m_dp = dp; m_lz = blank_lz;
      end
    end
    m_pend = load ? 1'b1 : (wrap ? 1'b0 : m_pend);
    m_pos  = enable ? (m_pos + 1) % NPOS : 0;
  endtask

  // One clock: advance the model, then compare every output just after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("dp_out", 32'(dp_out), 32'(e_dp));
    check("sel_out", 32'(sel_out), 32'(e_sel));
    check("frame_done", 32'(fd), 32'(e_fd));
    check("seg_out_hex0", 32'(seg_h0), 32'(e_seg0));
    check("sel_out_hex0", 32'(sel_h0), 32'(e_sel));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic run_to_pos(input int p);
    for (int k = 0; k < NPOS && m_pos != p; k++) cyc();
  endtask

  task automatic do_load(input logic [15:0] nums, input logic [3:0] en, input logic [3:0] dpv, input logic lz);
    numbers = nums; digit_en = en; dp = dpv; blank_lz = lz; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int lat, per;
    rst_N = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
    numbers = '0; digit_en = '0; dp = '0;
    model_reset();
    #1 rst_N = 1'b0;
    #1;
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_sel", 32'(sel_out), 32'hF);
    check("rst_fd", 32'(fd), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_N = 1'b1;

    // Basic scan with first-select latency and frame period.
    do_load(16'h4321, 4'hF, 4'b0100, 1'b0);
    enable = 1'b1;
    lat = 0;
    do begin cyc(); lat++; end while (sel_out === 4'hF && lat < 20);
    check("first_sel_latency", 32'(lat), 32'd3);
    check("first_sel", 32'(sel_out), 32'hE);
    check("first_seg", 32'(seg_out), 32'(7'b1111001));
    lat = 0;
    do begin cyc(); lat++; end while (fd !== 1'b1 && lat < 100);
    per = 0;
    do begin cyc(); per++; end while (fd !== 1'b1 && per < 100);
    check("frame_period", 32'(per), 32'd32);
    run(NPOS + 5);

    // Reset mid-slot: outputs dark asynchronously, scan restarts from digit 0.
    #2 rst_N = 1'b0;
    #1;
    check("midrst_seg", 32'(seg_out), 32'h7F);
    check("midrst_dp", 32'(dp_out), 32'h1);
    check("midrst_sel", 32'(sel_out), 32'hF);
    check("midrst_fd", 32'(fd), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_N = 1'b1;
    run(NPOS);

    // Decode in both hex modes.
    do_load(16'hFA98, 4'hF, 4'h0, 1'b0);
    run(2 * NPOS + 3);

    // Leading-zero blanking.
    do_load(16'h0050, 4'hF, 4'hF, 1'b1);
    run(2 * NPOS + 1);
    do_load(16'h0000, 4'hF, 4'hF, 1'b1);
    run(2 * NPOS + 1);

    // Tear-free update mid-frame and coincident with the wrap cycle.
    do_load(16'h1111, 4'hF, 4'h0, 1'b0);
    run(2 * NPOS);
    run_to_pos(CLK_DIV + 3);
    do_load(16'h2222, 4'hF, 4'h0, 1'b0);
    run(2 * NPOS);
    run_to_pos(NPOS - 1);
    do_load(16'h3333, 4'hF, 4'h0, 1'b0);
    run(2 * NPOS + 2);

    // Enable toggle, load while disabled, re-enable.
    run_to_pos(2 * CLK_DIV + 4);
    enable = 1'b0;
    cyc();
    check("disable_sel", 32'(sel_out), 32'hF);
    run(4);
    do_load(16'h9999, 4'hF, 4'h0, 1'b0);
    enable = 1'b1;
    run(DEAD + 1);
    check("reenable_seg", 32'(seg_out), 32'(7'b0010000));
    check("reenable_sel", 32'(sel_out), 32'hE);
    run(NPOS);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if ($urandom_range(0, 15) == 0) begin
        numbers  = 16'($urandom);
        if ($urandom_range(0, 3) == 0) numbers[15:8] = 8'h00;
        digit_en = 4'($urandom);
        dp       = 4'($urandom);
        blank_lz = 1'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      cyc();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
